lif_array: RTL and testbench
============================

Name: lif_array

Overview:
- Parametrised, time-multiplexed array of leaky integrate-and-fire neurons; the next generation of the single-neuron lif block.
- A single shared update datapath visits one channel per enabled clock, round-robin.
- Per-channel membrane state and refractory counters are held in register arrays.
- Adds a runtime threshold, a refractory period, saturating integration, and a spike event stream tagged with channel index. Sits behind the chip top-level wrapper, fed from dedicated inputs.

Parameters:
- WIDTH, 8, bit width of membrane state, input current and threshold.
- CHANNELS, 4, number of neurons (>=2).
- LEAK_SHIFT, 1, leak is state>>LEAK_SHIFT per visit (must be >=1).
- REFRACT, 2, visits a channel is held at 0 after spiking (0 = none).

Ports:
- clk, input, 1, system clock, all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- en, input, 1, advance scheduler; when 0 nothing updates.
- current, input, CHANNELS*WIDTH, packed per-channel input current; channel k at [k*WIDTH +: WIDTH].
- threshold, input, WIDTH, firing threshold, sampled on each visit.
- state_out, output, WIDTH, post-update membrane state of last visited channel.
- state_ch, output, clog2(CHANNELS), channel index of state_out.
- spike_valid, output, 1, one-cycle pulse: last visited channel fired.
- spike_ch, output, clog2(CHANNELS), channel of the spike, valid with spike_valid.
- step_done, output, 1, one-cycle pulse after channel CHANNELS-1 updated.
- spike_vec, output, CHANNELS, spike bits of the last completed step.

Behaviour:
- Reset (async, reset_n=0):
  - All states, refractory counters, ptr, state_out, state_ch, spike_valid, spike_ch, step_done and spike_vec are 0.
  - Takes effect immediately, mid-step included; the partial-step spike accumulator is cleared. First enabled cycle after release visits channel 0.
- Scheduler: ptr in 0..CHANNELS-1. On each clock with en=1, update channel ptr, then ptr <= ptr+1, wrapping CHANNELS-1 -> 0.
- en=0: ptr, arrays and spike_vec hold. spike_valid and step_done go 0. state_out and state_ch hold.
- Update of channel k = ptr, with s = state[k], c = current slice k:
  - refr[k] > 0: state[k] <= 0, refr[k] <= refr[k]-1, no spike.
  - Else:
    - leaked = s - (s >> LEAK_SHIFT).
    - sum = leaked + c, computed at WIDTH+1 bits; clamp to 2^WIDTH-1 on overflow.
    - If sum >= threshold: spike; state[k] <= 0; refr[k] <= REFRACT.
    - Else: state[k] <= sum.
  - threshold=0 therefore spikes on every non-refractory visit.
- Latency 1 clock: outputs update on the same edge that writes the arrays.
  - state_out gets the new state[k]; state_ch <= k.
  - spike_valid and spike_ch reflect the visit; spike_ch holds its last value when no spike.
- Step accumulator: an internal CHANNELS-bit vector ORs in each spike.
  - On the k=CHANNELS-1 update, spike_vec <= accumulator including this visit's spike; step_done pulses; accumulator clears.
- threshold and current may change on any cycle; only the value at the visiting edge matters.
- Refractory counter width clog2(REFRACT+1), minimum 1.

Decomposition:
- Package lif_pkg holds:
  - default parameter constants;
  - the clog2 helper;
  - a sat_add function (WIDTH+1 sum, clamp).
- One combinational sub-module, lif_core: inputs s, c, refr, threshold; outputs next_s, next_refr, fire.
- lif_array holds only the scheduler, arrays and output registers.

Test Plan:
(defaults WIDTH=8, CHANNELS=4, LEAK_SHIFT=1, REFRACT=2; one visit per channel every 4 enabled clocks)
- Reset: hold reset_n=0 for 3 clocks, release with en=1 and all current 0 -> all outputs 0; first state_ch=0; step_done pulses on the 4th enabled clock; spike_vec=0.
- Integration: threshold=200, ch0 current=100, others 0 -> ch0 state_out sequence 100,150,175,188,194,197,199. On visit 8, sum=200 fires: spike_valid=1, spike_ch=0, state 0. Visits 9-10 state held 0 (refractory); visit 11 gives 100.
- Saturation: threshold=255, ch2 current=200 -> visit 1 state 200; visit 2 sum 300 clamps to 255, fires, spike_ch=2; spike_vec=4'b0100 at that step_done.
- Concurrency: threshold=0, all currents 1 -> spike on four consecutive clocks, spike_ch 0,1,2,3; spike_vec=4'b1111. Next two steps have no spikes (refractory); the third step spikes again.
- Stall: deassert en for 5 clocks mid-step at ptr=2 -> no pulses, state_ch held; resuming visits ch2 next with identical state results.
- Reset mid-operation: reset_n=0 at ptr=3 with ch1 mid-integration -> immediate zero outputs; after release ch1 restarts from 0 and visit order begins at ch0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

  localparam int unsigned LIF_WIDTH      = 8;
  localparam int unsigned LIF_CHANNELS   = 4;
  localparam int unsigned LIF_LEAK_SHIFT = 1;
  localparam int unsigned LIF_REFRACT    = 2;

  // Ceiling log2, never below 1 so that single-value indices still get a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Unsigned add of two w-bit values, clamped to 2^w-1 on carry-out.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_core.sv
// Combinational single-visit neuron update: leak, saturating integrate, fire, refractory.
module lif_core
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH      = LIF_WIDTH,
  parameter int unsigned LEAK_SHIFT = LIF_LEAK_SHIFT,
  parameter int unsigned REFRACT    = LIF_REFRACT,
  parameter int unsigned RW         = clog2(REFRACT + 1)
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  input  logic [RW-1:0]    refr,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] next_s,
  output logic [RW-1:0]    next_refr,
  output logic             fire
);

  logic [WIDTH-1:0] w_leaked;
  logic [WIDTH-1:0] w_sum;

  assign w_leaked = s - (s >> LEAK_SHIFT);
  assign w_sum    = WIDTH'(sat_add(32'(w_leaked), 32'(c), WIDTH));

  always_comb begin
    next_s    = '0;
    next_refr = '0;
    fire      = 1'b0;
    if (refr != '0) begin
      next_refr = refr - RW'(1);
    end else if (w_sum >= threshold) begin
      fire      = 1'b1;
      next_refr = RW'(REFRACT);
    end else begin
      next_s = w_sum;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Round-robin scheduler, per-channel state arrays and registered outputs around lif_core.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH      = LIF_WIDTH,
  parameter int unsigned CHANNELS   = LIF_CHANNELS,
  parameter int unsigned LEAK_SHIFT = LIF_LEAK_SHIFT,
  parameter int unsigned REFRACT    = LIF_REFRACT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic [CHANNELS*WIDTH-1:0]    current,
  input  logic [WIDTH-1:0]             threshold,
  output logic [WIDTH-1:0]             state_out,
  output logic [clog2(CHANNELS)-1:0]   state_ch,
  output logic                         spike_valid,
  output logic [clog2(CHANNELS)-1:0]   spike_ch,
  output logic                         step_done,
  output logic [CHANNELS-1:0]          spike_vec
);

  localparam int unsigned PW = clog2(CHANNELS);
  localparam int unsigned RW = clog2(REFRACT + 1);

  logic [WIDTH-1:0]    r_state [CHANNELS];
  logic [RW-1:0]       r_refr  [CHANNELS];
  logic [PW-1:0]       r_ptr;
  logic [CHANNELS-1:0] r_acc;

  logic [WIDTH-1:0]    w_c;
  logic [WIDTH-1:0]    w_next_s;
  logic [RW-1:0]       w_next_refr;
  logic                w_fire;
  logic                w_last;
  logic [CHANNELS-1:0] w_acc_next;

  assign w_c        = current[r_ptr*WIDTH +: WIDTH];
  assign w_last     = (r_ptr == PW'(CHANNELS - 1));
  assign w_acc_next = r_acc | (CHANNELS'(w_fire) << r_ptr);

  lif_core #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT),
    .RW         (RW)
  ) u_core (
    .s         (r_state[r_ptr]),
    .c         (w_c),
    .refr      (r_refr[r_ptr]),
    .threshold (threshold),
    .next_s    (w_next_s),
    .next_refr (w_next_refr),
    .fire      (w_fire)
  );

  // Array write and output registers share the visiting edge: one-clock latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= '0;
        r_refr[i]  <= '0;
      end
      r_ptr       <= '0;
      r_acc       <= '0;
      state_out   <= '0;
      state_ch    <= '0;
      spike_valid <= 1'b0;
      spike_ch    <= '0;
      step_done   <= 1'b0;
      spike_vec   <= '0;
    end else if (en) begin
      r_state[r_ptr] <= w_next_s;
      r_refr[r_ptr]  <= w_next_refr;
      r_ptr          <= w_last ? '0 : r_ptr + PW'(1);
      state_out      <= w_next_s;
      state_ch       <= r_ptr;
      spike_valid    <= w_fire;
      if (w_fire) spike_ch <= r_ptr;
      step_done      <= w_last;
      if (w_last) begin
        spike_vec <= w_acc_next;
        r_acc     <= '0;
      end else begin
        r_acc <= w_acc_next;
      end
    end else begin
      spike_valid <= 1'b0;
      step_done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// Scoreboarded bench for lif_array: behavioural model predicts every clock's outputs.
module tb_lif_array;

  localparam int W = 8;
  localparam int C = 4;
  localparam int L = 1;
  localparam int R = 2;
  localparam int MAXV = (1 << W) - 1;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic [C*W-1:0]   current;
  logic [W-1:0]     threshold;
  logic [W-1:0]     state_out;
  logic [1:0]       state_ch;
  logic             spike_valid;
  logic [1:0]       spike_ch;
  logic             step_done;
  logic [C-1:0]     spike_vec;

  lif_array #(.WIDTH(W), .CHANNELS(C), .LEAK_SHIFT(L), .REFRACT(R)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .current     (current),
    .threshold   (threshold),
    .state_out   (state_out),
    .state_ch    (state_ch),
    .spike_valid (spike_valid),
    .spike_ch    (spike_ch),
    .step_done   (step_done),
    .spike_vec   (spike_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int so;
    int sch;
    int sv;
    int sp;
    int sd;
    int vec;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_st [C];
  int m_rf [C];
  int m_ptr;
  int m_acc;
  exp_t m_out;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_st[i] = 0;
      m_rf[i] = 0;
    end
    m_ptr = 0;
    m_acc = 0;
    m_out = '{0, 0, 0, 0, 0, 0};
  endtask

  task automatic model_step(input bit rst_n_v, input bit en_v,
                            input logic [C*W-1:0] cur, input int thr);
    int k, s, c, sum, ns, f;
    if (!rst_n_v) begin
      model_reset();
    end else if (en_v) begin
      k = m_ptr;
      s = m_st[k];
      c = (cur >> (k * W)) & MAXV;
      f = 0;
      if (m_rf[k] > 0) begin
        ns = 0;
        m_rf[k] = m_rf[k] - 1;
      end else begin
        sum = s - s / (1 << L) + c;
        if (sum > MAXV) sum = MAXV;
        if (sum >= thr) begin
          f = 1;
          ns = 0;
          m_rf[k] = R;
        end else begin
          ns = sum;
        end
      end
      m_st[k] = ns;
      m_out.so  = ns;
      m_out.sch = k;
      m_out.sv  = f;
      if (f) m_out.sp = k;
      if (f) m_acc = m_acc | (1 << k);
      if (k == C - 1) begin
        m_out.vec = m_acc;
        m_out.sd  = 1;
        m_acc     = 0;
      end else begin
        m_out.sd = 0;
      end
      m_ptr = (m_ptr + 1) % C;
    end else begin
      m_out.sv = 0;
      m_out.sd = 0;
    end
    q.push_back(m_out);
  endtask

  // Drive one clock's inputs at the falling edge and queue the predicted response.
  task automatic drive(input bit rst_n_v, input bit en_v,
                       input logic [C*W-1:0] cur, input int thr);
    @(negedge clk);
    reset_n   = rst_n_v;
    en        = en_v;
    current   = cur;
    threshold = W'(thr);
    model_step(rst_n_v, en_v, cur, thr);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 0);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clock the DUT presents a full output set; compare with the head of queue.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state_out",   int'(state_out),   e.so);
      chk("state_ch",    int'(state_ch),    e.sch);
      chk("spike_valid", int'(spike_valid), e.sv);
      chk("spike_ch",    int'(spike_ch),    e.sp);
      chk("step_done",   int'(step_done),   e.sd);
      chk("spike_vec",   int'(spike_vec),   e.vec);
    end
  end

  int integ_exp [11] = '{100, 150, 175, 188, 194, 197, 199, 0, 0, 0, 100};
  int integ_spk [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    reset_n   = 1'b0;
    en        = 1'b0;
    current   = '0;
    threshold = '0;
    model_reset();

    // Reset then idle integration with zero current
    do_reset();
    chk("reset_state_out", int'(state_out), 0);
    chk("reset_spike_vec", int'(spike_vec), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, '0, 200);
      sample();
      if (i == 0) chk("first_state_ch", int'(state_ch), 0);
      chk("reset_step_done", int'(step_done), (i == 3) ? 1 : 0);
    end

    // Integration on ch0 up to threshold, refractory, restart
    do_reset();
    for (int v = 0; v < 11; v++) begin
      for (int k = 0; k < C; k++) begin
        drive(1'b1, 1'b1, {8'd0, 8'd0, 8'd0, 8'd100}, 200);
        if (k == 0) begin
          sample();
          chk("integ_state", int'(state_out), integ_exp[v]);
          chk("integ_spike", int'(spike_valid), integ_spk[v]);
        end
      end
    end

    // Saturation on ch2
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, {8'd0, 8'd200, 8'd0, 8'd0}, 255);
      if (i == 2 || i == 6) begin
        sample();
        chk("sat_state", int'(state_out), (i == 2) ? 200 : 0);
        chk("sat_spike", int'(spike_valid), (i == 2) ? 0 : 1);
      end
      if (i == 7) begin
        sample();
        chk("sat_vec", int'(spike_vec), 4'b0100);
      end
    end

    // All channels fire together at threshold 0, then sit out two steps
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, {8'd1, 8'd1, 8'd1, 8'd1}, 0);
      if (i % 4 == 3) begin
        sample();
        chk("conc_vec", int'(spike_vec), (i == 3 || i == 15) ? 4'b1111 : 4'b0000);
      end
    end

    // Stall mid-step at ptr=2
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, {8'd30, 8'd40, 8'd50, 8'd60}, 200);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, {8'd99, 8'd99, 8'd99, 8'd99}, 0);
    sample();
    chk("stall_state_ch", int'(state_ch), 1);
    drive(1'b1, 1'b1, {8'd30, 8'd40, 8'd50, 8'd60}, 200);
    sample();
    chk("resume_state_ch", int'(state_ch), 2);

    // Async reset mid-step with ch1 integrating
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, {8'd0, 8'd0, 8'd100, 8'd0}, 200);
    drive(1'b0, 1'b0, '0, 200);
    #1;
    chk("midrst_state_out", int'(state_out), 0);
    chk("midrst_state_ch",  int'(state_ch), 0);
    chk("midrst_step_done", int'(step_done), 0);
    drive(1'b0, 1'b0, '0, 200);
    drive(1'b1, 1'b1, {8'd0, 8'd0, 8'd100, 8'd0}, 200);
    sample();
    chk("midrst_first_ch", int'(state_ch), 0);
    drive(1'b1, 1'b1, {8'd0, 8'd0, 8'd100, 8'd0}, 200);
    sample();
    chk("midrst_ch1_state", int'(state_out), 100);

    // Randomised traffic with occasional reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
            C*W'($urandom), int'($urandom_range(0, 255)));
    end
    drive(1'b1, 1'b0, '0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
